// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: I2S transmit timing and sample scheduler.
// Derives SCLK/LRCLK pin levels and a shift tick from the master clock, buffers one
// stereo sample from a valid/ready source and issues one load strobe per frame.
// Ports:
//   i_clk_12_288, i_reset_n        master clock, async active-low reset
//   i_enable                       run request (level)
//   i_sample_valid/_l/_r           upstream sample, o_sample_ready = holding register empty
//   o_sclk, o_lrclk                I2S pin levels (lrclk 0 = left)
//   o_sclk_tick                    one-cycle shift enable (combinational from the frame counter)
//   o_data_valid, o_audio_l/_r     registered one-cycle load strobe and sample to load
//   o_underrun, o_underrun_cnt     underrun pulse and saturating underrun count
//   o_busy                         state != IDLE
// Build option: define I2S_TX_CTRL_REPEAT_EN to repeat the last sample on underrun
// instead of loading zeros.
module i2s_tx_ctrl #(
    parameter int DATA_BIT         = 16,
    parameter int SCLK_COUNT       = 64,
    parameter int MCLK_LRCLK_RATIO = 256,
    parameter int UNDERRUN_W       = 8
) (
    input  logic                  i_clk_12_288,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_sample_valid,
    input  logic [DATA_BIT-1:0]   i_sample_l,
    input  logic [DATA_BIT-1:0]   i_sample_r,
    output logic                  o_sample_ready,
    output logic                  o_sclk,
    output logic                  o_lrclk,
    output logic                  o_sclk_tick,
    output logic                  o_data_valid,
    output logic [DATA_BIT-1:0]   o_audio_l,
    output logic [DATA_BIT-1:0]   o_audio_r,
    output logic                  o_underrun,
    output logic [UNDERRUN_W-1:0] o_underrun_cnt,
    output logic                  o_busy
);
    localparam int DIV = MCLK_LRCLK_RATIO / SCLK_COUNT;
    localparam int CW  = $clog2(MCLK_LRCLK_RATIO);
    localparam int DW  = $clog2(DIV);
    localparam int BW  = CW - DW;
    localparam logic [CW-1:0] LAST   = CW'(MCLK_LRCLK_RATIO - 1);
    localparam logic [CW-1:0] DECIDE = CW'(MCLK_LRCLK_RATIO - 2);
    localparam logic [BW-1:0] LR_LO  = BW'(SCLK_COUNT / 2 - 1);
    localparam logic [BW-1:0] LR_HI  = BW'(SCLK_COUNT - 2);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic [DATA_BIT-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_BIT-1:0]   audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic [DATA_BIT-1:0]   fill_l, fill_r;
    logic                  dv_q, dv_d, ur_q, ur_d;
    logic [UNDERRUN_W-1:0] ucnt_q, ucnt_d;
    logic                  busy, last, decide, hs;
    logic [BW-1:0]         bit_idx;

`ifdef I2S_TX_CTRL_REPEAT_EN
    assign fill_l = audio_l_q;
    assign fill_r = audio_r_q;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    assign busy    = state_q != IDLE;
    assign last    = cnt_q == LAST;
    // Loads are only scheduled while running; a STOP frame drains without loading.
    assign decide  = state_q == RUN && cnt_q == DECIDE;
    assign hs      = i_sample_valid && !full_q;
    // DIV is a power of two, so cnt mod DIV and cnt / DIV are plain bit fields.
    assign bit_idx = cnt_q[CW-1:DW];

    assign o_busy         = busy;
    assign o_sample_ready = !full_q;
    assign o_sclk         = busy && cnt_q[DW-1];
    // LRCLK leads the word by one SCLK for the standard I2S one-bit delay.
    assign o_lrclk        = busy && bit_idx >= LR_LO && bit_idx <= LR_HI;
    // No tick on the load cycle, so the serializer never shifts and loads together.
    assign o_sclk_tick    = busy && (&cnt_q[DW-1:0]) && !last;
    assign o_data_valid   = dv_q;
    assign o_audio_l      = audio_l_q;
    assign o_audio_r      = audio_r_q;
    assign o_underrun     = ur_q;
    assign o_underrun_cnt = ucnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_enable) state_d = RUN;
            RUN:     if (!i_enable) state_d = STOP;
            STOP:    if (i_enable) state_d = RUN;
                     else if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = busy ? (last ? '0 : cnt_q + CW'(1)) : '0;
        // A bypass handshake on the decision cycle goes straight to the output.
        full_d    = decide ? 1'b0 : (full_q || hs);
        hold_l_d  = (hs && !decide) ? i_sample_l : hold_l_q;
        hold_r_d  = (hs && !decide) ? i_sample_r : hold_r_q;
        audio_l_d = !decide ? audio_l_q : full_q ? hold_l_q : hs ? i_sample_l : fill_l;
        audio_r_d = !decide ? audio_r_q : full_q ? hold_r_q : hs ? i_sample_r : fill_r;
        dv_d      = decide;
        ur_d      = decide && !full_q && !hs;
        ucnt_d    = (ur_d && !(&ucnt_q)) ? ucnt_q + UNDERRUN_W'(1) : ucnt_q;
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            dv_q      <= 1'b0;
            ur_q      <= 1'b0;
            ucnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            dv_q      <= dv_d;
            ur_q      <= ur_d;
            ucnt_q    <= ucnt_d;
        end
    end
endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb_i2s_tx_ctrl: directed scoreboard bench for i2s_tx_ctrl with default parameters.
module tb_i2s_tx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en = 1'b0, valid = 1'b0;
    logic [15:0] sl = '0, sr = '0;
    logic        o_sample_ready, o_sclk, o_lrclk, o_sclk_tick, o_data_valid, o_underrun, o_busy;
    logic [15:0] o_audio_l, o_audio_r;
    logic [7:0]  o_underrun_cnt;

    always #5 clk = ~clk;

    i2s_tx_ctrl #(
        .DATA_BIT(16), .SCLK_COUNT(64), .MCLK_LRCLK_RATIO(256), .UNDERRUN_W(8)
    ) dut (
        .i_clk_12_288(clk), .i_reset_n(rst_n), .i_enable(en),
        .i_sample_valid(valid), .i_sample_l(sl), .i_sample_r(sr),
        .o_sample_ready(o_sample_ready), .o_sclk(o_sclk), .o_lrclk(o_lrclk),
        .o_sclk_tick(o_sclk_tick), .o_data_valid(o_data_valid),
        .o_audio_l(o_audio_l), .o_audio_r(o_audio_r), .o_underrun(o_underrun),
        .o_underrun_cnt(o_underrun_cnt), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0;
    int          m_state = 0, m_cnt = 0;
    int          ur_exp = 0;
    logic [15:0] last_l = '0, last_r = '0;
    bit          chk_on = 0, frame_ok = 0;
    int          tick_n = 0, bidx;
    logic        busy_e, sclk_e, lr_e, tick_e;
    exp_t        e;

    // Frame position model: 0 = idle, 1 = run, 2 = stop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
        end else begin
            m_cnt <= (m_state != 0) ? (m_cnt + 1) % 256 : 0;
            case (m_state)
                0:       if (en) m_state <= 1;
                1:       if (!en) m_state <= 2;
                default: if (en) m_state <= 1; else if (m_cnt == 255) m_state <= 0;
            endcase
        end
    end

    // Monitor: pin timing every cycle, scoreboard pop on each load strobe.
    always @(negedge clk) begin
        if (chk_on) begin
            busy_e = m_state != 0;
            bidx   = m_cnt / 4;
            sclk_e = busy_e && (m_cnt % 4) >= 2;
            lr_e   = busy_e && bidx >= 31 && bidx <= 62;
            tick_e = busy_e && (m_cnt % 4) == 3 && m_cnt != 255;
            tests++;
            if ({o_busy, o_sclk, o_lrclk, o_sclk_tick, o_underrun && !o_data_valid,
                 o_data_valid && m_cnt != 255} !== {busy_e, sclk_e, lr_e, tick_e, 2'b00}) begin
                fails++;
                $display("FAIL pins cnt=%0d: busy/sclk/lrclk/tick/stray_ur/stray_dv got %b%b%b%b%b%b expected %b%b%b%b00",
                         m_cnt, o_busy, o_sclk, o_lrclk, o_sclk_tick, o_underrun && !o_data_valid,
                         o_data_valid && m_cnt != 255, busy_e, sclk_e, lr_e, tick_e);
            end
            if (m_cnt == 0) begin
                frame_ok = busy_e;
                tick_n   = 0;
            end
            if (o_sclk_tick) tick_n++;
            if (m_cnt == 255 && frame_ok) begin
                tests++;
                if (tick_n != 63) begin
                    fails++;
                    $display("FAIL tick_count: got %0d expected 63", tick_n);
                end
            end
            if (o_data_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL load_unexpected: got load l=%h r=%h ur=%b, expected none",
                             o_audio_l, o_audio_r, o_underrun);
                end else begin
                    e = q.pop_front();
                    if ({o_audio_l, o_audio_r, o_underrun} !== e) begin
                        fails++;
                        $display("FAIL load: got l=%h r=%h ur=%b expected l=%h r=%h ur=%b",
                                 o_audio_l, o_audio_r, o_underrun, e.l, e.r, e.ur);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_cnt(input int n);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (m_cnt != n && k < 600);
        if (m_cnt != n) begin
            tests++;
            fails++;
            $display("FAIL wait_cnt: got cnt %0d expected %0d", m_cnt, n);
        end
    endtask

    task automatic push_exp(input logic [15:0] l, input logic [15:0] r, input logic ur);
        exp_t x;
        x.l = l;
        x.r = r;
        x.ur = ur;
        q.push_back(x);
        last_l = l;
        last_r = r;
        if (ur && ur_exp < 255) ur_exp++;
    endtask

    task automatic push_under();
`ifdef I2S_TX_CTRL_REPEAT_EN
        push_exp(last_l, last_r, 1'b1);
`else
        push_exp(16'h0, 16'h0, 1'b1);
`endif
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        valid = 1'b1;
        sl = l;
        sr = r;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_on = 1;
        repeat (2) @(negedge clk);
        chk("reset_flags", 64'({o_sclk, o_lrclk, o_sclk_tick, o_data_valid, o_underrun, o_busy, o_sample_ready}), 64'h1);
        chk("reset_audio", 64'({o_audio_l, o_audio_r}), 64'h0);
        chk("reset_ucnt", 64'(o_underrun_cnt), 64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_pins", 64'({o_sclk, o_lrclk, o_busy}), 64'h0);

        // Prefill in IDLE, then first frame loads it.
        send(16'hA5A5, 16'h3C3C);
        chk("prefill_ready", 64'(o_sample_ready), 64'h0);
        push_exp(16'hA5A5, 16'h3C3C, 1'b0);
        en = 1'b1;
        wait_cnt(255);
        chk("load_ready", 64'(o_sample_ready), 64'h1);

        // Three starved frames.
        for (int i = 0; i < 3; i++) begin
            push_under();
            wait_cnt(255);
        end
        chk("ucnt_3", 64'(o_underrun_cnt), 64'd3);

        // Bypass: handshake on the decision cycle while empty.
        wait_cnt(254);
        chk("bypass_ready_pre", 64'(o_sample_ready), 64'h1);
        push_exp(16'h1234, 16'h5678, 1'b0);
        send(16'h1234, 16'h5678);
        chk("bypass_ready_post", 64'(o_sample_ready), 64'h1);
        chk("bypass_no_underrun", 64'(o_underrun_cnt), 64'd3);

        // Drive the counter into saturation.
        for (int i = 0; i < 257; i++) begin
            push_under();
            wait_cnt(255);
        end
        chk("ucnt_sat", 64'(o_underrun_cnt), 64'd255);
        chk("ucnt_model", 64'(ur_exp), 64'd255);

        // Drop enable mid-frame with a held sample: frame drains, no load, sample kept.
        wait_cnt(10);
        send(16'hBEEF, 16'hCAFE);
        chk("held_ready", 64'(o_sample_ready), 64'h0);
        wait_cnt(100);
        en = 1'b0;
        wait_cnt(255);
        chk("stop_no_load", 64'(o_data_valid), 64'h0);
        chk("stop_held", 64'(o_sample_ready), 64'h0);
        @(negedge clk);
        chk("stop_idle", 64'({o_busy, o_sclk, o_lrclk}), 64'h0);

        // Re-enable: the retained sample goes out on the next frame.
        push_exp(16'hBEEF, 16'hCAFE, 1'b0);
        en = 1'b1;
        wait_cnt(255);
        chk("reload_ready", 64'(o_sample_ready), 64'h1);

        // Reset mid-frame with a full holding register.
        wait_cnt(10);
        send(16'h1111, 16'h2222);
        chk("pre_reset_full", 64'(o_sample_ready), 64'h0);
        wait_cnt(128);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", 64'({o_sclk, o_lrclk, o_sclk_tick, o_data_valid, o_underrun, o_busy, o_sample_ready}), 64'h1);
        chk("midrst_audio", 64'({o_audio_l, o_audio_r}), 64'h0);
        chk("midrst_ucnt", 64'(o_underrun_cnt), 64'h0);
        en = 1'b0;
        ur_exp = 0;
        last_l = '0;
        last_r = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_empty", 64'(o_sample_ready), 64'h1);
        chk("scoreboard_drained", 64'(q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
